// File: rtl/cmp_unit_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_unit_pipe_if
//  Description : Handshake and data bundle for cmp_unit_pipe.
//                Input side : a, b, alu_fun, cmp_enable (valid), cmp_ready
//                Output side: cmp_out, cmp_res, cmp_flag (valid), out_ready
//                Statistics : cmp_clear, cmp_count
//                Optional   : cmp_signed (only when CMP_SIGNED_EN is defined)
//                Modports   : master (producer/consumer side), slave (comparator)
//  Revision    : 1.0  initial release
// ============================================================================
interface cmp_unit_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           alu_fun;
    logic                 cmp_enable;
    logic                 cmp_ready;
    logic [3:0]           cmp_out;
    logic [WIDTH-1:0]     cmp_res;
    logic                 cmp_flag;
    logic                 out_ready;
    logic                 cmp_clear;
    logic [CNT_WIDTH-1:0] cmp_count;
`ifdef CMP_SIGNED_EN
    logic                 cmp_signed;
`endif

    modport master (
        output a, b, alu_fun, cmp_enable, out_ready, cmp_clear,
`ifdef CMP_SIGNED_EN
        output cmp_signed,
`endif
        input  cmp_ready, cmp_out, cmp_res, cmp_flag, cmp_count
    );

    modport slave (
        input  a, b, alu_fun, cmp_enable, out_ready, cmp_clear,
`ifdef CMP_SIGNED_EN
        input  cmp_signed,
`endif
        output cmp_ready, cmp_out, cmp_res, cmp_flag, cmp_count
    );
endinterface
`default_nettype wire

// File: rtl/cmp_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_unit_pipe
//  Description : Two-stage pipelined comparator with valid/ready handshake on
//                both sides and a saturating count of true comparisons.
//                Stage 1 registers operands and function, stage 2 evaluates
//                and registers the result code / selected operand.
//  Ports       : clk   - clock
//                rst_n - asynchronous reset, active low
//                bus   - cmp_unit_pipe_if.slave (operands, handshakes,
//                        results, counter clear/value)
//  Macro       : CMP_SIGNED_EN - adds bus.cmp_signed; selects two's complement
//                ordering for GT/LT/GE/MIN/MAX per operation.
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_unit_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    cmp_unit_pipe_if.slave  bus
);
    localparam logic [2:0] c_FUN_NOP = 3'b000;
    localparam logic [2:0] c_FUN_EQ  = 3'b001;
    localparam logic [2:0] c_FUN_GT  = 3'b010;
    localparam logic [2:0] c_FUN_LT  = 3'b011;
    localparam logic [2:0] c_FUN_NE  = 3'b100;
    localparam logic [2:0] c_FUN_GE  = 3'b101;
    localparam logic [2:0] c_FUN_MIN = 3'b110;
    localparam logic [2:0] c_FUN_MAX = 3'b111;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    // Stage 1
    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;
    logic [2:0]           r_s1_fun;
    // Stage 2 / outputs
    logic                 r_flag;
    logic [3:0]           r_out;
    logic [WIDTH-1:0]     r_res;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic [WIDTH-1:0]     w_key_a;
    logic [WIDTH-1:0]     w_key_b;
    logic                 w_eq;
    logic                 w_lt;
    logic                 w_gt;
    logic                 w_true;
    logic [3:0]           w_code;
    logic [WIDTH-1:0]     w_res;

    assign w_s2_adv = !r_flag || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

`ifdef CMP_SIGNED_EN
    logic r_s1_sgn;

    // Flipping the MSB maps two's complement order onto unsigned order,
    // so a single unsigned comparator serves both modes.
    assign w_key_a = {r_s1_a[WIDTH-1] ^ r_s1_sgn, r_s1_a[WIDTH-2:0]};
    assign w_key_b = {r_s1_b[WIDTH-1] ^ r_s1_sgn, r_s1_b[WIDTH-2:0]};
`else
    assign w_key_a = r_s1_a;
    assign w_key_b = r_s1_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_fun   <= c_FUN_NOP;
`ifdef CMP_SIGNED_EN
            r_s1_sgn   <= 1'b0;
`endif
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.cmp_enable;
            if (bus.cmp_enable) begin
                r_s1_a   <= bus.a;
                r_s1_b   <= bus.b;
                r_s1_fun <= bus.alu_fun;
`ifdef CMP_SIGNED_EN
                r_s1_sgn <= bus.cmp_signed;
`endif
            end
        end
    end

    assign w_eq = (r_s1_a == r_s1_b);
    assign w_lt = (w_key_a < w_key_b);
    assign w_gt = (w_key_b < w_key_a);

    // w_true marks only the predicate functions; it feeds the match counter.
    always_comb begin
        w_true = 1'b0;
        w_code = 4'd0;
        w_res  = '0;
        case (r_s1_fun)
            c_FUN_EQ:  w_true = w_eq;
            c_FUN_GT:  w_true = w_gt;
            c_FUN_LT:  w_true = w_lt;
            c_FUN_NE:  w_true = !w_eq;
            c_FUN_GE:  w_true = !w_lt;
            c_FUN_MIN: begin
                w_code = 4'd6;
                w_res  = w_gt ? r_s1_b : r_s1_a;   // ties return A
            end
            c_FUN_MAX: begin
                w_code = 4'd7;
                w_res  = w_lt ? r_s1_b : r_s1_a;   // ties return A
            end
            default: ;
        endcase
        // A true predicate reports its own function number as the code.
        if (w_true) begin
            w_code = {1'b0, r_s1_fun};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_out  <= 4'd0;
            r_res  <= '0;
        end else if (w_s2_adv) begin
            r_flag <= r_s1_valid;
            r_out  <= r_s1_valid ? w_code : 4'd0;
            r_res  <= r_s1_valid ? w_res  : '0;
        end
    end

    // Counts at the moment a result enters stage 2; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.cmp_clear) begin
            r_cnt <= '0;
        end else if (w_s2_adv && r_s1_valid && w_true && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign bus.cmp_ready = w_s1_adv;
    assign bus.cmp_out   = r_out;
    assign bus.cmp_res   = r_res;
    assign bus.cmp_flag  = r_flag;
    assign bus.cmp_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmp_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_unit_pipe
//  Description : Self-checking bench for cmp_unit_pipe (WIDTH=8, CNT_WIDTH=4).
//                Table vectors and generated ops feed a pending queue; accepted
//                ops move their expected result into a scoreboard that is
//                compared when the DUT hands a result downstream.
//  Macro       : CMP_SIGNED_EN - also exercises the signed compare mode.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmp_unit_pipe;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] fun;
        logic       sgn;
        logic [3:0] eo;
        logic [7:0] er;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    vec_t tbl[16];
    vec_t pend[$];
    vec_t sb[$];
    int   pop_cyc[$];

    cmp_unit_pipe_if #(.WIDTH(8), .CNT_WIDTH(4)) bus ();

    cmp_unit_pipe #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Independent reference: integer ordering, sign-extended when requested.
    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] fun, input logic sgn);
        vec_t v;
        int   ia, ib;
        ia = sgn ? int'($signed(a)) : int'({24'd0, a});
        ib = sgn ? int'($signed(b)) : int'({24'd0, b});
        v.a = a; v.b = b; v.fun = fun; v.sgn = sgn; v.eo = 4'd0; v.er = 8'd0;
        case (fun)
            3'd1: v.eo = (a == b) ? 4'd1 : 4'd0;
            3'd2: v.eo = (ia > ib)  ? 4'd2 : 4'd0;
            3'd3: v.eo = (ia < ib)  ? 4'd3 : 4'd0;
            3'd4: v.eo = (a != b) ? 4'd4 : 4'd0;
            3'd5: v.eo = (ia >= ib) ? 4'd5 : 4'd0;
            3'd6: begin v.eo = 4'd6; v.er = (ib < ia) ? b : a; end
            3'd7: begin v.eo = 4'd7; v.er = (ib > ia) ? b : a; end
            default: ;
        endcase
        return v;
    endfunction

    // One clock: drive the head pending op, note handshakes, compare results.
    task automatic cycle();
        vec_t v, e;
        if (pend.size() > 0) begin
            v = pend[0];
            bus.a = v.a; bus.b = v.b; bus.alu_fun = v.fun;
`ifdef CMP_SIGNED_EN
            bus.cmp_signed = v.sgn;
`endif
            bus.cmp_enable = 1'b1;
        end else begin
            bus.cmp_enable = 1'b0;
        end
        #1;
        if (bus.cmp_flag && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("out a=%h b=%h f=%0d", e.a, e.b, e.fun), bus.cmp_out, e.eo);
                chk($sformatf("res a=%h b=%h f=%0d", e.a, e.b, e.fun), bus.cmp_res, e.er);
                pop_cyc.push_back(cyc);
            end
        end
        if (bus.cmp_enable && bus.cmp_ready) begin
            sb.push_back(pend.pop_front());
            n_acc++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (pend.size() > 0 || sb.size() > 0); i++) cycle();
        chk("drain_left", pend.size() + sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s_out;
        logic [7:0] s_res;
        logic [7:0] r;

        tbl[0]  = '{8'h35, 8'h35, 3'd1, 1'b0, 4'd1, 8'h00};
        tbl[1]  = '{8'h80, 8'h7F, 3'd2, 1'b0, 4'd2, 8'h00};
        tbl[2]  = '{8'h10, 8'h0C, 3'd6, 1'b0, 4'd6, 8'h0C};
        tbl[3]  = '{8'h10, 8'h0C, 3'd7, 1'b0, 4'd7, 8'h10};
        tbl[4]  = '{8'h00, 8'h00, 3'd1, 1'b0, 4'd1, 8'h00};
        tbl[5]  = '{8'hFF, 8'hFF, 3'd1, 1'b0, 4'd1, 8'h00};
        tbl[6]  = '{8'h01, 8'h02, 3'd2, 1'b0, 4'd0, 8'h00};
        tbl[7]  = '{8'h01, 8'h02, 3'd3, 1'b0, 4'd3, 8'h00};
        tbl[8]  = '{8'h05, 8'h05, 3'd4, 1'b0, 4'd0, 8'h00};
        tbl[9]  = '{8'h05, 8'h06, 3'd4, 1'b0, 4'd4, 8'h00};
        tbl[10] = '{8'h05, 8'h05, 3'd5, 1'b0, 4'd5, 8'h00};
        tbl[11] = '{8'h04, 8'h05, 3'd5, 1'b0, 4'd0, 8'h00};
        tbl[12] = '{8'hAA, 8'h55, 3'd0, 1'b0, 4'd0, 8'h00};
        tbl[13] = '{8'h33, 8'h33, 3'd6, 1'b0, 4'd6, 8'h33};
        tbl[14] = '{8'hFF, 8'h00, 3'd7, 1'b0, 4'd7, 8'hFF};
        tbl[15] = '{8'h00, 8'hFF, 3'd3, 1'b0, 4'd3, 8'h00};

        rst_n = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.alu_fun = 3'd0;
        bus.cmp_enable = 1'b0; bus.out_ready = 1'b1; bus.cmp_clear = 1'b0;
`ifdef CMP_SIGNED_EN
        bus.cmp_signed = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_flag", bus.cmp_flag, 0);
        chk("rst_out", bus.cmp_out, 0);
        chk("rst_res", bus.cmp_res, 0);
        chk("rst_count", bus.cmp_count, 0);
        rst_n = 1'b1;
        #1 chk("rst_ready", bus.cmp_ready, 1);
        @(negedge clk);

        // Latency: result flagged exactly two edges after the handshake
        pend.push_back(tbl[0]);
        cycle();
        chk("lat_t1_flag", bus.cmp_flag, 0);
        cycle();
        chk("lat_t2_flag", bus.cmp_flag, 1);
        chk("lat_t2_out", bus.cmp_out, 1);

        // Rest of the function table
        for (int i = 1; i < 16; i++) pend.push_back(tbl[i]);
        drain();
        chk("table_count", bus.cmp_count, 8);

        // Backpressure: output stalled for 7 cycles with 4 ops queued
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 4; i++)
            pend.push_back(mk(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0));
        repeat (2) cycle();
        s_out = bus.cmp_out;
        s_res = bus.cmp_res;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_flag_hold", bus.cmp_flag, 1);
            chk("bp_out_hold", bus.cmp_out, s_out);
            chk("bp_res_hold", bus.cmp_res, s_res);
            chk("bp_ready_low", bus.cmp_ready, 0);
        end
        chk("bp_accepted", n_acc, 2);
        bus.out_ready = 1'b1;
        drain();

        // Counter: clear, partial count, saturation, clear priority
        bus.cmp_clear = 1'b1;
        cycle();
        bus.cmp_clear = 1'b0;
        chk("cnt_clear", bus.cmp_count, 0);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            pend.push_back(mk(r, r, 3'd1, 1'b0));
        end
        pend.push_back(mk(8'h01, 8'h02, 3'd1, 1'b0));
        pend.push_back(mk(8'h09, 8'h09, 3'd4, 1'b0));
        drain();
        chk("cnt_three", bus.cmp_count, 3);
        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom);
            pend.push_back(mk(r, r, 3'd1, 1'b0));
        end
        drain();
        chk("cnt_saturate", bus.cmp_count, 15);
        pend.push_back(mk(8'h42, 8'h42, 3'd1, 1'b0));
        cycle();
        bus.cmp_clear = 1'b1;
        cycle();
        bus.cmp_clear = 1'b0;
        chk("cnt_clear_prio", bus.cmp_count, 0);
        drain();
        chk("cnt_after_prio", bus.cmp_count, 0);

`ifdef CMP_SIGNED_EN
        // Signed mode, mixed with unsigned ops in flight
        pend.push_back('{8'hFF, 8'h01, 3'd2, 1'b1, 4'd0, 8'h00});
        pend.push_back('{8'hFF, 8'h01, 3'd2, 1'b0, 4'd2, 8'h00});
        pend.push_back('{8'h80, 8'h7F, 3'd7, 1'b1, 4'd7, 8'h7F});
        pend.push_back('{8'h80, 8'h7F, 3'd6, 1'b1, 4'd6, 8'h80});
        pend.push_back('{8'hFF, 8'h01, 3'd3, 1'b1, 4'd3, 8'h00});
        pend.push_back('{8'h80, 8'h80, 3'd1, 1'b1, 4'd1, 8'h00});
        pend.push_back('{8'h80, 8'h7F, 3'd7, 1'b0, 4'd7, 8'h80});
        for (int i = 0; i < 8; i++)
            pend.push_back(mk(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                              1'($urandom_range(0, 1))));
        drain();
`endif

        // Throughput: 16 ops produce 16 results on consecutive cycles
        pop_cyc.delete();
        for (int i = 0; i < 16; i++)
            pend.push_back(mk(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0));
        drain();
        chk("tp_results", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16) chk("tp_span", pop_cyc[15] - pop_cyc[0], 15);

        // Reset mid-stream with a valid result on the output
        for (int i = 0; i < 4; i++) pend.push_back(mk(8'h77, 8'h77, 3'd1, 1'b0));
        repeat (3) cycle();
        chk("mid_pre_flag", bus.cmp_flag, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flag", bus.cmp_flag, 0);
        chk("mid_rst_out", bus.cmp_out, 0);
        chk("mid_rst_res", bus.cmp_res, 0);
        chk("mid_rst_count", bus.cmp_count, 0);
        pend.delete();
        sb.delete();
        bus.cmp_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rel_ready", bus.cmp_ready, 1);
        @(negedge clk);
        pend.push_back(tbl[2]);
        pend.push_back(tbl[3]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
